// File: rtl/comet_ii_prog_loader.sv
// Boot-time program loader: parses a framed host byte stream into 16-bit RAM
// writes, then hands the RAM write port to the CPU and releases cpu_init.
module comet_ii_prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DATA_W    = 16
) (
  input  logic              mclk,
  input  logic              init,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_we,
  output logic [15:0]       mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_init,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM, DONE, ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       addr_reg, cnt_reg;
  logic [7:0]        csum_reg, hi_reg;
  logic              loader_we_reg;
  logic [15:0]       waddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              in_ready_reg, done_reg, err_reg, cpu_init_reg;
  logic              xfer;
  logic              csum_byte;

  assign xfer = in_valid && in_ready_reg;

  // Header and data bytes contribute to the checksum; SYNC and CSUM do not.
  assign csum_byte = (state_reg == ADDR_H) || (state_reg == ADDR_L) ||
                     (state_reg == CNT_H)  || (state_reg == CNT_L)  ||
                     (state_reg == DATA_H) || (state_reg == DATA_L);

  always_ff @(posedge mclk or negedge init) begin
    if (!init) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (xfer) begin
      case (state_reg)
        IDLE:    if (in_data == SYNC_BYTE) state_next = ADDR_H;
        ADDR_H:  state_next = ADDR_L;
        ADDR_L:  state_next = CNT_H;
        CNT_H:   state_next = CNT_L;
        CNT_L:   state_next = ({cnt_reg[15:8], in_data} == 16'd0) ? CSUM : DATA_H;
        DATA_H:  state_next = DATA_L;
        DATA_L:  state_next = (cnt_reg == 16'd1) ? CSUM : DATA_H;
        CSUM:    state_next = (in_data == csum_reg) ? DONE : ERR;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge init) begin
    if (!init) begin
      addr_reg      <= '0;
      cnt_reg       <= '0;
      csum_reg      <= '0;
      hi_reg        <= '0;
      loader_we_reg <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      in_ready_reg  <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cpu_init_reg  <= 1'b0;
    end else begin
      loader_we_reg <= 1'b0;
      in_ready_reg  <= !((state_next == DONE) || (state_next == ERR));
      done_reg      <= (state_next == DONE);
      err_reg       <= (state_next == ERR);
      cpu_init_reg  <= (state_next == DONE);
      if (xfer) begin
        if (csum_byte) csum_reg <= csum_reg ^ in_data;
        case (state_reg)
          IDLE: begin
            if (in_data == SYNC_BYTE) begin
              csum_reg <= '0;
              addr_reg <= '0;
              cnt_reg  <= '0;
            end
          end
          ADDR_H: addr_reg[15:8] <= in_data;
          ADDR_L: addr_reg[7:0]  <= in_data;
          CNT_H:  cnt_reg[15:8]  <= in_data;
          CNT_L:  cnt_reg[7:0]   <= in_data;
          DATA_H: hi_reg         <= in_data;
          DATA_L: begin
            // Strobe lands one cycle after the low byte; address wraps naturally.
            loader_we_reg <= 1'b1;
            waddr_reg     <= addr_reg;
            wdata_reg     <= {hi_reg, in_data};
            addr_reg      <= addr_reg + 16'd1;
            cnt_reg       <= cnt_reg - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Once loaded the CPU owns the RAM write port with no added latency.
  always_comb begin
    in_ready  = in_ready_reg;
    done      = done_reg;
    err       = err_reg;
    cpu_init  = cpu_init_reg;
    mem_we    = loader_we_reg;
    mem_waddr = waddr_reg;
    mem_wdata = wdata_reg;
    if (done_reg) begin
      mem_we    = cpu_we;
      mem_waddr = cpu_waddr;
      mem_wdata = cpu_wdata;
    end
  end

endmodule

// File: tb/tb_comet_ii_prog_loader.sv
// Directed bench for comet_ii_prog_loader: frames are driven byte by byte,
// expected RAM writes are queued at stimulus time and checked as strobes appear.
module tb_comet_ii_prog_loader;

  logic        mclk;
  logic        init;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cpu_we;
  logic [15:0] cpu_waddr;
  logic [15:0] cpu_wdata;
  logic        mem_we;
  logic [15:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        cpu_init;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [31:0] exp_q[$];
  int          wr_cycles[$];
  logic [31:0] exp_w;
  logic        pt_mode = 1'b0;
  logic        prev_we = 1'b0;
  logic [15:0] words[8];

  comet_ii_prog_loader #(.SYNC_BYTE(8'hA5), .DATA_W(16)) dut (
    .mclk(mclk), .init(init), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cpu_we(cpu_we), .cpu_waddr(cpu_waddr),
    .cpu_wdata(cpu_wdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_init(cpu_init), .done(done), .err(err)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  always @(posedge mclk) cycle++;

  // Write scoreboard: every loader strobe must match the oldest queued write.
  always @(negedge mclk) begin
    if (mem_we && !pt_mode) begin
      checks++;
      assert (exp_q.size() > 0 && !prev_we) else begin
        failures++;
        $error("FAIL unexpected_write got addr=%h data=%h prev_we=%b required none", mem_waddr, mem_wdata, prev_we);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        checks++;
        assert ({mem_waddr, mem_wdata} === exp_w) else begin
          failures++;
          $error("FAIL write_data got %h:%h required %h:%h", mem_waddr, mem_wdata, exp_w[31:16], exp_w[15:0]);
        end
        wr_cycles.push_back(cycle);
      end
    end
    prev_we = mem_we && !pt_mode;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
    checks++;
    assert (got === req) else begin
      failures++;
      $error("FAIL %s got=%h required=%h", tag, got, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      @(negedge mclk);
      in_valid = 1'b0;
    end
    @(negedge mclk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge mclk);
      t++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge mclk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] addr, input logic [15:0] n,
                            input logic bad, input int gap);
    logic [7:0]  cs;
    logic [15:0] a;
    logic [15:0] w;
    cs = 8'h00;
    a  = addr;
    send_byte(8'hA5, gap);
    send_byte(addr[15:8], gap); cs ^= addr[15:8];
    send_byte(addr[7:0], gap);  cs ^= addr[7:0];
    send_byte(n[15:8], gap);    cs ^= n[15:8];
    send_byte(n[7:0], gap);     cs ^= n[7:0];
    for (int i = 0; i < int'(n); i++) begin
      w = words[i];
      send_byte(w[15:8], gap);  cs ^= w[15:8];
      exp_q.push_back({a, w});
      send_byte(w[7:0], gap);   cs ^= w[7:0];
      a = a + 16'd1;
    end
    cpu_we = 1'b0;
    chk("cpu_init_before_csum", {31'd0, cpu_init}, 32'd0);
    send_byte(bad ? ~cs : cs, gap);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge mclk);
    in_valid = 1'b0;
    cpu_we   = 1'b0;
    pt_mode  = 1'b0;
    init     = 1'b0;
    #1;
    chk("rst_outputs", {25'd0, in_ready, done, err, cpu_init, mem_we, |mem_waddr, |mem_wdata}, 32'd0);
    @(negedge mclk);
    @(negedge mclk);
    init = 1'b1;
    @(negedge mclk);
    chk("rst_in_ready_up", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_done();
    chk("done_flags", {28'd0, done, cpu_init, err, in_ready}, {28'd0, 4'b1100});
  endtask

  initial begin
    init = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_we = 1'b0; cpu_waddr = 16'h0000; cpu_wdata = 16'h0000;
    #1;
    chk("reset_state", {28'd0, in_ready, done, err, cpu_init}, 32'd0);
    chk("reset_mem", {15'd0, mem_we, mem_waddr}, 32'd0);
    @(negedge mclk);
    @(negedge mclk);
    init = 1'b1;
    chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge mclk);
    chk("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Two-word frame, back to back; CPU bus must be ignored while loading.
    cpu_we = 1'b1; cpu_waddr = 16'hDEAD; cpu_wdata = 16'h5555;
    words[0] = 16'h1234; words[1] = 16'hABCD;
    wr_cycles.delete();
    send_frame(16'h0100, 16'd2, 1'b0, 0);
    check_done();
    chk("frame1_writes", wr_cycles.size(), 32'd2);
    if (wr_cycles.size() == 2) chk("write_spacing", wr_cycles[1] - wr_cycles[0], 32'd2);
    chk("frame1_queue_empty", exp_q.size(), 32'd0);
    do_reset();

    // Leading garbage, then a one-word frame.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    words[0] = 16'hC0DE;
    send_frame(16'h0300, 16'd1, 1'b0, 0);
    check_done();
    chk("garbage_queue_empty", exp_q.size(), 32'd0);
    do_reset();

    // Address wrap with idle gaps between bytes; includes an in-frame SYNC value.
    words[0] = 16'h1111; words[1] = 16'hA5A5;
    send_frame(16'hFFFF, 16'd2, 1'b0, 2);
    check_done();
    chk("wrap_queue_empty", exp_q.size(), 32'd0);
    do_reset();

    // Bad checksum: word stays written, ERR is sticky and refuses bytes.
    words[0] = 16'h5678;
    send_frame(16'h0200, 16'd1, 1'b1, 0);
    chk("err_flags", {28'd0, done, cpu_init, err, in_ready}, {28'd0, 4'b0010});
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      chk("err_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("err_queue_empty", exp_q.size(), 32'd0);
    do_reset();

    // Zero-count frame, then CPU pass-through once loaded.
    send_frame(16'h0100, 16'd0, 1'b0, 0);
    check_done();
    @(negedge mclk);
    pt_mode = 1'b1;
    cpu_we = 1'b1; cpu_waddr = 16'h0050; cpu_wdata = 16'hBEEF;
    #1;
    chk("pt_we", {31'd0, mem_we}, 32'd1);
    chk("pt_addr_data", {mem_waddr, mem_wdata}, 32'h0050BEEF);
    cpu_we = 1'b0; cpu_waddr = 16'h1234;
    #1;
    chk("pt_follow", {15'd0, mem_we, mem_waddr}, 32'h00001234);
    do_reset();

    // Reset after DATA_H while the low byte is offered: no strobe, clean restart.
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
    @(negedge mclk);
    in_valid = 1'b1; in_data = 8'h34;
    init = 1'b0;
    #1;
    chk("mid_rst_outputs", {25'd0, in_ready, done, err, cpu_init, mem_we, |mem_waddr, |mem_wdata}, 32'd0);
    in_valid = 1'b0;
    do_reset();

    // Reset right after the DATA_L handshake cancels the pending strobe.
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    init = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("pending_strobe_cancel", {31'd0, mem_we}, 32'd0);
    do_reset();

    words[0] = 16'h0F0F;
    send_frame(16'h0400, 16'd1, 1'b0, 0);
    check_done();
    repeat (3) @(negedge mclk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout got=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
